// File: rtl/knapsack_search.sv
// Brute-force subset enumerator: steps a candidate select vector through every
// subset, consults an external combinational checker, and records the results.
module knapsack_search #(
  parameter int N_ITEMS = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               stop_on_first,
  output logic [N_ITEMS-1:0] sel,
  input  logic               valid_in,
  output logic               busy,
  output logic               done,
  output logic               found,
  output logic [N_ITEMS-1:0] first_sel,
  output logic [N_ITEMS-1:0] last_sel,
  output logic [N_ITEMS:0]   valid_count,
  output logic [1:0]         dbg_state
);

  // Handshake: start is a one-cycle request honoured only in IDLE; valid_in
  // must be the checker's same-cycle verdict for the sel currently driven.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [N_ITEMS-1:0] SEL_LAST = '1;
  localparam logic [N_ITEMS-1:0] SEL_ONE  = {{(N_ITEMS-1){1'b0}}, 1'b1};
  localparam logic [N_ITEMS:0]   CNT_ONE  = {{N_ITEMS{1'b0}}, 1'b1};

  state_t               state, state_next;
  logic                 stop_latched, stop_latched_next;
  logic [N_ITEMS-1:0]   sel_next;
  logic                 found_next;
  logic [N_ITEMS-1:0]   first_sel_next, last_sel_next;
  logic [N_ITEMS:0]     valid_count_next;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      stop_latched <= 1'b0;
      sel          <= '0;
      found        <= 1'b0;
      first_sel    <= '0;
      last_sel     <= '0;
      valid_count  <= '0;
    end else begin
      state        <= state_next;
      stop_latched <= stop_latched_next;
      sel          <= sel_next;
      found        <= found_next;
      first_sel    <= first_sel_next;
      last_sel     <= last_sel_next;
      valid_count  <= valid_count_next;
    end
  end

  always_comb begin
    state_next        = state;
    stop_latched_next = stop_latched;
    sel_next          = sel;
    found_next        = found;
    first_sel_next    = first_sel;
    last_sel_next     = last_sel;
    valid_count_next  = valid_count;

    case (state)
      IDLE: begin
        if (start) begin
          state_next        = SCAN;
          stop_latched_next = stop_on_first;
          sel_next          = '0;
          found_next        = 1'b0;
          first_sel_next    = '0;
          last_sel_next     = '0;
          valid_count_next  = '0;
        end
      end

      SCAN: begin
        if (valid_in) begin
          valid_count_next = valid_count + CNT_ONE;
          last_sel_next    = sel;
          if (!found) begin
            first_sel_next = sel;
            found_next     = 1'b1;
          end
        end
        // The all-ones candidate ends the scan so sel never wraps back to zero.
        if ((sel == SEL_LAST) || (valid_in && stop_latched)) begin
          state_next = DONE;
        end else begin
          sel_next = sel + SEL_ONE;
        end
      end

      DONE: begin
        state_next = IDLE;
      end

      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign busy      = (state == SCAN);
  assign done      = (state == DONE);
  assign dbg_state = state;

endmodule

// File: doc/knapsack_search.md
KNAPSACK_SEARCH -- requirements
Module: knapsack_search

Interface
REQ-001 SHALL have parameter N_ITEMS, default 5: number of item-select bits presented to the downstream validity checker.
REQ-002 SHALL have port clk  input  1: single clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n  input  1: reset, asynchronous and active-low.
REQ-004 SHALL have port start  input  1: one-cycle request to begin a search; sampled only in IDLE.
REQ-005 SHALL have port stop_on_first  input  1: sampled with start; 1 = halt at first valid subset, 0 = exhaustive scan.
REQ-006 SHALL have port sel  output  N_ITEMS: registered candidate subset driven to checker; bit i = item i selected (bit0 = item A).
REQ-007 SHALL have port valid_in  input  1: combinational verdict from checker for the current sel, same cycle.
REQ-008 SHALL have port busy  output  1: high while in SCAN.
REQ-009 SHALL have port done  output  1: one-cycle pulse when a search completes.
REQ-010 SHALL have port found  output  1: at least one valid subset seen in the last search.
REQ-011 SHALL have port first_sel  output  N_ITEMS: lowest-index valid subset of the last search.
REQ-012 SHALL have port last_sel  output  N_ITEMS: highest-index valid subset of the last search.
REQ-013 SHALL have port valid_count  output  N_ITEMS+1: number of valid subsets seen in the last search.

Function
REQ-014 SHALL implement states IDLE, SCAN, DONE, encoded in a registered state variable.
REQ-015 IDLE: on start=1, SHALL latch stop_on_first, set sel=0, clear found, first_sel, last_sel, valid_count, and enter SCAN next cycle.
REQ-016 IDLE with start=0 SHALL hold all outputs; sel holds its last value.
REQ-017 SCAN: each cycle SHALL sample valid_in against the current sel; exactly one candidate evaluated per cycle.
REQ-018 On valid_in=1 in SCAN: valid_count += 1; last_sel <= sel; if found=0 then first_sel <= sel and found <= 1.
REQ-019 SCAN SHALL exit to DONE when sel = 2^N_ITEMS-1, or when valid_in=1 and the latched stop_on_first=1; otherwise sel <= sel+1.
REQ-020 sel SHALL never wrap to 0 within a search; the all-ones candidate is the last one evaluated.
REQ-021 DONE: done=1 for exactly one cycle, then IDLE; result outputs hold until the next accepted start.
REQ-022 Latency: start accepted at edge t -> SCAN from t+1; exhaustive search with N_ITEMS=5 asserts done in the cycle after 32 SCAN cycles (t+33).
REQ-023 start asserted while in SCAN or DONE SHALL be ignored, with no queuing.
REQ-024 valid_count SHALL be wide enough that an all-valid scan (2^N_ITEMS) does not overflow.
REQ-025 busy SHALL be 1 exactly in SCAN; done and busy SHALL never be high together.

Reset
REQ-026 rst_n=0 SHALL immediately force IDLE, sel=0, busy=0, done=0, found=0, first_sel=0, last_sel=0, valid_count=0.
REQ-027 Reset asserted mid-SCAN SHALL abort the search with no done pulse; after release the block waits in IDLE for start.

Verification
REQ-028 Exhaustive scan, N_ITEMS=5, checker for capacity 16 kg, min value $15 (items A..E = $4/12, $2/1, $2/2, $1/1, $10/4): start, stop_on_first=0 -> done at t+33, found=1, valid_count=1, first_sel=last_sel=5'b11110.
REQ-029 Same checker, stop_on_first=1 -> done after 31 SCAN cycles, first_sel=5'b11110, valid_count=1, and sel not incremented past 5'b11110.
REQ-030 Checker tied to valid_in=1 -> valid_count=32, first_sel=5'b00000, last_sel=5'b11111, no overflow.
REQ-031 Checker tied to 0 -> found=0, valid_count=0, done at t+33; a second start during SCAN is ignored, with exactly one done pulse.
REQ-032 rst_n pulsed low at SCAN cycle 10 -> outputs zero asynchronously, no done; a new start then yields results identical to REQ-028.
